life_sequencer: RTL and testbench
=================================

// Module: life_sequencer
// PURPOSE
//  Run-control sequencer for the 8x8 Game-of-Life next-generation datapath.
//  - Owns the 64-bit grid register and feeds it to the combinational datapath.
//  - Loads a seed, then advances one generation per programmable tick period (run, pause, single-step).
//  - Counts generations and halts on a stable grid, an extinct grid or a generation limit.
//  - Sits between the top-level switch/button inputs and the datapath; the display logic reads grid.
// PARAMETERS
//  GRID_W    64  grid bits (8x8, bit 8*row+col)
//  PERIOD_W  24  width of tick period / divider counter
//  GEN_W     16  width of generation counter and limit
// PORTS
//  clk        in   1         system clock
//  reset      in   1         asynchronous, active-low reset (0 = reset)
//  load       in   1         copy seed into grid, return to IDLE
//  seed       in   GRID_W    initial pattern
//  start      in   1         enter/resume RUN
//  pause      in   1         RUN -> PAUSE
//  step       in   1         single generation advance (IDLE/PAUSE only)
//  period     in   PERIOD_W  clk cycles per generation in RUN; 0 treated as 1
//  max_gen    in   GEN_W     halt limit; 0 = no limit
//  next_grid  in   GRID_W    datapath result for current grid
//  grid       out  GRID_W    current generation (drives datapath input)
//  generation out  GEN_W     generations since load, saturating
//  running    out  1         state == RUN
//  halted     out  1         state == HALT
//  stable     out  1         last advance produced next_grid == grid
//  extinct    out  1         last advance produced next_grid == 0
//  gen_pulse  out  1         one-cycle pulse, high the cycle after each advance
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - state=IDLE; grid=0, generation=0, divider=0.
//    - All flags and gen_pulse = 0.
//  - All outputs registered.
//  - Command priority per cycle: load > pause > start > step.
//  - load (any state):
//    - grid<=seed, generation<=0, divider<=0.
//    - stable/extinct<=0, state<=IDLE; no advance that cycle.
//  - Advance (edge of cycle where advance condition holds):
//    - grid<=next_grid; generation<=generation+1, holds at all-ones.
//    - stable<=(next_grid==grid); extinct<=(next_grid==0).
//    - gen_pulse=1 for the next cycle.
//  - States:
//    - IDLE:
//      - start -> RUN, divider<=0.
//      - step -> one advance, stay IDLE.
//    - RUN:
//      - divider counts 0..eff_period-1 (eff_period = period==0 ? 1 : period).
//      - At terminal count: advance, divider<=0.
//      - pause -> PAUSE; divider held, no advance that cycle.
//      - start and step ignored.
//    - PAUSE:
//      - start -> RUN, divider resumes from held value.
//      - step -> one advance, stay PAUSE.
//    - HALT: grid, generation and flags frozen; only load or reset exits.
//  - Halt check, on every advance:
//    - Go to HALT if the new stable, the new extinct, or the new generation == max_gen (max_gen != 0).
//    - An advance from IDLE/PAUSE also goes to HALT on these conditions.
//  - period changed mid-RUN: applies immediately.
//    - If divider >= new eff_period-1, the next cycle advances and the divider wraps to 0.
//  - step held high advances once per cycle in IDLE/PAUSE (no edge detection here; debounce upstream).
//  - Simultaneous stable and extinct (grid already 0): both flags set.
//  - Reset mid-run aborts immediately; no partial grid update.
// STRUCTURE
//  - life_pkg:
//    - typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_HALT} life_state_t.
//    - localparam GRID_W = 64.
//  - Sub-module tick_divider: PERIOD_W counter with clear, hold, period input and terminal-count output.
//  - Top level: grid register, generation counter, state machine, compare logic.
// TESTING (datapath instantiated, edge cells see dead neighbours)
//  1. reset=0 mid-RUN, period=3 -> all outputs 0 and state IDLE within the same cycle; held until release.
//  2. Blinker: load seed=64'h0E00, period=2, start.
//     - grid alternates 64'h40404 / 64'h0E00 every 2 cycles; generation 1,2,3...
//     - gen_pulse on each advance; stable never set.
//  3. Block: load seed=64'h303, start, period=0.
//     - Advance on the first RUN cycle; stable=1, halted=1, generation=1, grid=64'h303.
//  4. Extinction: load seed=64'h1, step in IDLE.
//     - grid=0, extinct=1, halted=1, generation=1.
//     - Further start/step ignored until load.
//  5. Limit and pause: blinker, max_gen=5, period=1, start.
//     - pause after gen 2: grid frozen; step -> gen 3.
//     - start -> HALT at generation=5, grid=64'h40404.
//  6. Priority: load+pause+start in the same cycle while RUN -> grid=seed, gen=0, state IDLE, no advance.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and default sizes for the Game-of-Life run-control sequencer.
package life_pkg;

  localparam int GRID_W   = 64;
  localparam int PERIOD_W = 24;
  localparam int GEN_W    = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_HALT  = 2'd3
  } life_state_t;

  // Normalise a requested tick period: zero is treated as one cycle.
  function automatic logic [PERIOD_W-1:0] eff_period(input logic [PERIOD_W-1:0] p);
    if (p == {PERIOD_W{1'b0}}) begin
      eff_period = {{(PERIOD_W-1){1'b0}}, 1'b1};
    end else begin
      eff_period = p;
    end
  endfunction

endpackage

// File: rtl/life_sequencer_tick_divider.sv
// Generation tick divider: counts 0..eff_period-1 while enabled, holds otherwise.
// The terminal count is a compare against the live period input, so a period
// change takes effect on the very next cycle; a count already at or past the
// new terminal value fires and wraps to zero.
module tick_divider
  import life_pkg::*;
#(
  parameter int PERIOD_W = life_pkg::PERIOD_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic                tc
);

  logic [PERIOD_W-1:0] count_r;
  logic [PERIOD_W-1:0] last_s;

  // Terminal value of the count for the current (normalised) period.
  always_comb begin
    last_s = PERIOD_W'(eff_period(24'(period))) - {{(PERIOD_W-1){1'b0}}, 1'b1};
    tc     = (count_r >= last_s);
  end

  // Divider counter: clear wins, then count/wrap while enabled, else hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {PERIOD_W{1'b0}};
    end else if (clear) begin
      count_r <= {PERIOD_W{1'b0}};
    end else if (enable) begin
      if (tc) begin
        count_r <= {PERIOD_W{1'b0}};
      end else begin
        count_r <= count_r + {{(PERIOD_W-1){1'b0}}, 1'b1};
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/life_sequencer.sv
// Run-control sequencer for the 8x8 Game-of-Life datapath: owns the grid
// register, advances it on a programmable tick (run/pause/single-step),
// counts generations and halts on stable, extinct or generation limit.
module life_sequencer #(
  parameter int GRID_W   = life_pkg::GRID_W,
  parameter int PERIOD_W = life_pkg::PERIOD_W,
  parameter int GEN_W    = life_pkg::GEN_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [GRID_W-1:0]   seed,
  input  logic                start,
  input  logic                pause,
  input  logic                step,
  input  logic [PERIOD_W-1:0] period,
  input  logic [GEN_W-1:0]    max_gen,
  input  logic [GRID_W-1:0]   next_grid,
  output logic [GRID_W-1:0]   grid,
  output logic [GEN_W-1:0]    generation,
  output logic                running,
  output logic                halted,
  output logic                stable,
  output logic                extinct,
  output logic                gen_pulse
);

  import life_pkg::*;

  life_state_t         state_r;
  life_state_t         state_cmd_s;
  life_state_t         state_next_s;
  logic [GRID_W-1:0]   grid_r;
  logic [GEN_W-1:0]    gen_r;
  logic                running_r;
  logic                halted_r;
  logic                stable_r;
  logic                extinct_r;
  logic                gen_pulse_r;

  logic                advance_s;
  logic                div_clear_s;
  logic                div_enable_s;
  logic                div_tc_s;
  logic                new_stable_s;
  logic                new_extinct_s;
  logic [GEN_W-1:0]    gen_inc_s;
  logic                limit_hit_s;
  logic                halt_cond_s;

  tick_divider #(
    .PERIOD_W (PERIOD_W)
  ) u_tick_divider (
    .clk    (clk),
    .reset  (reset),
    .clear  (div_clear_s),
    .enable (div_enable_s),
    .period (period),
    .tc     (div_tc_s)
  );

  // Outcome of a would-be advance: flags, saturating count and halt condition.
  always_comb begin
    new_stable_s  = (next_grid == grid_r);
    new_extinct_s = (next_grid == {GRID_W{1'b0}});
    if (gen_r == {GEN_W{1'b1}}) begin
      gen_inc_s = gen_r;
    end else begin
      gen_inc_s = gen_r + {{(GEN_W-1){1'b0}}, 1'b1};
    end
    limit_hit_s = (max_gen != {GEN_W{1'b0}}) && (gen_inc_s == max_gen);
    halt_cond_s = new_stable_s || new_extinct_s || limit_hit_s;
  end

  // Command decode and next state; priority load > pause > start > step.
  always_comb begin
    state_cmd_s  = state_r;
    advance_s    = 1'b0;
    div_clear_s  = 1'b0;
    div_enable_s = 1'b0;
    if (load) begin
      state_cmd_s = S_IDLE;
      div_clear_s = 1'b1;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_cmd_s = S_RUN;
            div_clear_s = 1'b1;
          end else if (step) begin
            advance_s = 1'b1;
          end else begin
            state_cmd_s = S_IDLE;
          end
        end
        S_RUN: begin
          if (pause) begin
            state_cmd_s = S_PAUSE;
          end else begin
            div_enable_s = 1'b1;
            advance_s    = div_tc_s;
          end
        end
        S_PAUSE: begin
          if (start) begin
            state_cmd_s = S_RUN;
          end else if (step) begin
            advance_s = 1'b1;
          end else begin
            state_cmd_s = S_PAUSE;
          end
        end
        S_HALT: begin
          state_cmd_s = S_HALT;
        end
        default: begin
          state_cmd_s = S_IDLE;
        end
      endcase
    end
    state_next_s = (advance_s && halt_cond_s) ? S_HALT : state_cmd_s;
  end

  // State register plus registered state-decode outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= S_IDLE;
      running_r <= 1'b0;
      halted_r  <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      running_r <= (state_next_s == S_RUN);
      halted_r  <= (state_next_s == S_HALT);
    end
  end

  // Grid, generation counter, result flags and advance pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grid_r      <= {GRID_W{1'b0}};
      gen_r       <= {GEN_W{1'b0}};
      stable_r    <= 1'b0;
      extinct_r   <= 1'b0;
      gen_pulse_r <= 1'b0;
    end else if (load) begin
      grid_r      <= seed;
      gen_r       <= {GEN_W{1'b0}};
      stable_r    <= 1'b0;
      extinct_r   <= 1'b0;
      gen_pulse_r <= 1'b0;
    end else if (advance_s) begin
      grid_r      <= next_grid;
      gen_r       <= gen_inc_s;
      stable_r    <= new_stable_s;
      extinct_r   <= new_extinct_s;
      gen_pulse_r <= 1'b1;
    end else begin
      gen_pulse_r <= 1'b0;
    end
  end

  assign grid       = grid_r;
  assign generation = gen_r;
  assign running    = running_r;
  assign halted     = halted_r;
  assign stable     = stable_r;
  assign extinct    = extinct_r;
  assign gen_pulse  = gen_pulse_r;

endmodule

// File: tb/tb_life_sequencer.sv
// Directed self-checking bench for life_sequencer with a behavioural
// 8x8 Game-of-Life datapath (cells outside the grid are dead).
module tb_life_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [63:0] seed;
  logic        start;
  logic        pause;
  logic        step;
  logic [23:0] period;
  logic [15:0] max_gen;
  logic [63:0] next_grid;
  logic [63:0] grid;
  logic [15:0] generation;
  logic        running;
  logic        halted;
  logic        stable;
  logic        extinct;
  logic        gen_pulse;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  life_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .seed       (seed),
    .start      (start),
    .pause      (pause),
    .step       (step),
    .period     (period),
    .max_gen    (max_gen),
    .next_grid  (next_grid),
    .grid       (grid),
    .generation (generation),
    .running    (running),
    .halted     (halted),
    .stable     (stable),
    .extinct    (extinct),
    .gen_pulse  (gen_pulse)
  );

  function automatic logic [63:0] life_next(input logic [63:0] g);
    logic [63:0] res;
    int n;
    res = 64'h0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && (r + dr) >= 0 && (r + dr) < 8 &&
                (c + dc) >= 0 && (c + dc) < 8) begin
              n = n + int'(g[(r + dr) * 8 + (c + dc)]);
            end
          end
        end
        res[r * 8 + c] = (n == 3) || (g[r * 8 + c] && n == 2);
      end
    end
    return res;
  endfunction

  assign next_grid = life_next(grid);

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [63:0] s);
    seed = s;
    load = 1'b1;
    cycle();
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; load = 1'b0; seed = 64'h0; start = 1'b0; pause = 1'b0;
    step = 1'b0; period = 24'd1; max_gen = 16'd0;
    cycle();
    checks++;
    if ({grid, generation, running, halted, stable, extinct, gen_pulse} !== 85'h0) begin
      errors++;
      $display("FAIL reset_outputs: got grid=%h gen=%0d run=%b halt=%b st=%b ex=%b gp=%b, expected all 0",
               grid, generation, running, halted, stable, extinct, gen_pulse);
    end
    reset = 1'b1;
    cycle();
    checks++;
    if ({grid, generation, running, halted} !== 82'h0) begin
      errors++;
      $display("FAIL reset_release: got grid=%h gen=%0d run=%b halt=%b, expected all 0",
               grid, generation, running, halted);
    end
  endtask

  task automatic test_blinker();
    logic [15:0] eg;
    logic [63:0] egrid;
    period = 24'd2; max_gen = 16'd0;
    do_load(64'h0E00);
    checks++;
    if (grid !== 64'h0E00 || generation !== 16'd0 || running !== 1'b0) begin
      errors++;
      $display("FAIL blinker_load: got grid=%h gen=%0d run=%b, expected 0e00/0/0", grid, generation, running);
    end
    start = 1'b1;
    cycle();
    start = 1'b0;
    checks++;
    if (running !== 1'b1 || generation !== 16'd0) begin
      errors++;
      $display("FAIL blinker_start: got run=%b gen=%0d, expected 1/0", running, generation);
    end
    for (int c = 1; c <= 8; c++) begin
      cycle();
      eg    = 16'(c / 2);
      egrid = eg[0] ? 64'h40404 : 64'h0E00;
      checks++;
      if (grid !== egrid || generation !== eg || gen_pulse !== (c % 2 == 0) || stable !== 1'b0) begin
        errors++;
        $display("FAIL blinker_c%0d: got grid=%h gen=%0d gp=%b st=%b, expected %h/%0d/%b/0",
                 c, grid, generation, gen_pulse, stable, egrid, eg, (c % 2 == 0));
      end
    end
  endtask

  task automatic test_block();
    period = 24'd0; max_gen = 16'd0;
    do_load(64'h303);
    start = 1'b1;
    cycle();
    start = 1'b0;
    checks++;
    if (running !== 1'b1 || generation !== 16'd0) begin
      errors++;
      $display("FAIL block_run: got run=%b gen=%0d, expected 1/0", running, generation);
    end
    cycle();
    checks++;
    if (grid !== 64'h303 || generation !== 16'd1 || stable !== 1'b1 || halted !== 1'b1 ||
        running !== 1'b0 || extinct !== 1'b0 || gen_pulse !== 1'b1) begin
      errors++;
      $display("FAIL block_halt: got grid=%h gen=%0d st=%b halt=%b run=%b ex=%b gp=%b, expected 303/1/1/1/0/0/1",
               grid, generation, stable, halted, running, extinct, gen_pulse);
    end
    cycle();
    checks++;
    if (generation !== 16'd1 || gen_pulse !== 1'b0 || halted !== 1'b1) begin
      errors++;
      $display("FAIL block_frozen: got gen=%0d gp=%b halt=%b, expected 1/0/1", generation, gen_pulse, halted);
    end
  endtask

  task automatic test_extinct();
    period = 24'd1; max_gen = 16'd0;
    do_load(64'h1);
    step = 1'b1;
    cycle();
    step = 1'b0;
    checks++;
    if (grid !== 64'h0 || extinct !== 1'b1 || halted !== 1'b1 || generation !== 16'd1 || stable !== 1'b0) begin
      errors++;
      $display("FAIL extinct_step: got grid=%h ex=%b halt=%b gen=%0d st=%b, expected 0/1/1/1/0",
               grid, extinct, halted, generation, stable);
    end
    start = 1'b1; step = 1'b1;
    cycle();
    cycle();
    start = 1'b0; step = 1'b0;
    checks++;
    if (generation !== 16'd1 || halted !== 1'b1 || running !== 1'b0 || gen_pulse !== 1'b0) begin
      errors++;
      $display("FAIL extinct_ignore: got gen=%0d halt=%b run=%b gp=%b, expected 1/1/0/0",
               generation, halted, running, gen_pulse);
    end
  endtask

  task automatic test_limit_pause();
    period = 24'd1; max_gen = 16'd5;
    do_load(64'h0E00);
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    checks++;
    if (generation !== 16'd2 || grid !== 64'h0E00) begin
      errors++;
      $display("FAIL limit_gen2: got gen=%0d grid=%h, expected 2/0e00", generation, grid);
    end
    pause = 1'b1;
    cycle();
    pause = 1'b0;
    cycle();
    checks++;
    if (generation !== 16'd2 || grid !== 64'h0E00 || running !== 1'b0 || halted !== 1'b0 || gen_pulse !== 1'b0) begin
      errors++;
      $display("FAIL pause_frozen: got gen=%0d grid=%h run=%b halt=%b gp=%b, expected 2/0e00/0/0/0",
               generation, grid, running, halted, gen_pulse);
    end
    step = 1'b1;
    cycle();
    step = 1'b0;
    checks++;
    if (generation !== 16'd3 || grid !== 64'h40404 || halted !== 1'b0 || running !== 1'b0) begin
      errors++;
      $display("FAIL pause_step: got gen=%0d grid=%h halt=%b run=%b, expected 3/40404/0/0",
               generation, grid, halted, running);
    end
    start = 1'b1;
    cycle();
    start = 1'b0;
    checks++;
    if (running !== 1'b1 || generation !== 16'd3) begin
      errors++;
      $display("FAIL resume: got run=%b gen=%0d, expected 1/3", running, generation);
    end
    cycle();
    cycle();
    checks++;
    if (generation !== 16'd5 || grid !== 64'h40404 || halted !== 1'b1 || running !== 1'b0 || stable !== 1'b0) begin
      errors++;
      $display("FAIL limit_halt: got gen=%0d grid=%h halt=%b run=%b st=%b, expected 5/40404/1/0/0",
               generation, grid, halted, running, stable);
    end
    cycle();
    checks++;
    if (generation !== 16'd5 || grid !== 64'h40404) begin
      errors++;
      $display("FAIL limit_frozen: got gen=%0d grid=%h, expected 5/40404", generation, grid);
    end
  endtask

  task automatic test_priority();
    period = 24'd4; max_gen = 16'd0;
    do_load(64'h0E00);
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    cycle();
    checks++;
    if (generation !== 16'd0 || running !== 1'b1) begin
      errors++;
      $display("FAIL prio_pre: got gen=%0d run=%b, expected 0/1", generation, running);
    end
    seed = 64'h0000_0000_0018_1800;
    load = 1'b1; pause = 1'b1; start = 1'b1;
    cycle();
    load = 1'b0; pause = 1'b0; start = 1'b0;
    checks++;
    if (grid !== 64'h0000_0000_0018_1800 || generation !== 16'd0 || running !== 1'b0 ||
        halted !== 1'b0 || gen_pulse !== 1'b0) begin
      errors++;
      $display("FAIL prio_load: got grid=%h gen=%0d run=%b halt=%b gp=%b, expected 181800/0/0/0/0",
               grid, generation, running, halted, gen_pulse);
    end
    cycle();
    checks++;
    if (grid !== 64'h0000_0000_0018_1800 || generation !== 16'd0 || running !== 1'b0) begin
      errors++;
      $display("FAIL prio_idle: got grid=%h gen=%0d run=%b, expected 181800/0/0", grid, generation, running);
    end
  endtask

  task automatic test_reset_midrun();
    period = 24'd3; max_gen = 16'd0;
    do_load(64'h0E00);
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    checks++;
    if (generation !== 16'd1 || running !== 1'b1) begin
      errors++;
      $display("FAIL midrun_pre: got gen=%0d run=%b, expected 1/1", generation, running);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({grid, generation, running, halted, stable, extinct, gen_pulse} !== 85'h0) begin
      errors++;
      $display("FAIL midrun_async: got grid=%h gen=%0d run=%b gp=%b, expected all 0",
               grid, generation, running, gen_pulse);
    end
    cycle();
    cycle();
    checks++;
    if ({grid, generation, running, halted, stable, extinct, gen_pulse} !== 85'h0) begin
      errors++;
      $display("FAIL midrun_held: got grid=%h gen=%0d run=%b gp=%b, expected all 0",
               grid, generation, running, gen_pulse);
    end
    reset = 1'b1;
    cycle();
    cycle();
    checks++;
    if (grid !== 64'h0 || generation !== 16'd0 || running !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL midrun_release: got grid=%h gen=%0d run=%b halt=%b, expected idle zeros",
               grid, generation, running, halted);
    end
  endtask

  initial begin
    test_reset();
    test_blinker();
    test_block();
    test_extinct();
    test_limit_pause();
    test_priority();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
